lcd_rgb_capture: RTL and testbench
==================================

// Module: lcd_rgb_capture
// PURPOSE
//  Receives a parallel RGB LCD video stream (de/hs/vs/rgb888) and converts it to RGB565.
//  Packs the pixels into SDRAM-width words and drives the sdram_top write-port FIFO (wr_en/wr_data/wr_load).
//  Pads each frame with zero words up to a whole number of full-page bursts, so every frame fills
//  exactly the IN_FRAME_LEN region. Sits upstream of sdram_top; it is the input-side counterpart of lcd_data.
// PARAMETERS
//  H_DISP     800  active pixels per line
//  V_DISP     480  active lines per frame
//  DATA_W     64   FIFO word width; PPW = DATA_W/16 pixels per word; H_DISP*V_DISP % PPW must be 0
//  BURST_LEN  256  full-page burst length in words; frame word count is rounded up to a multiple of this
//  VS_POL     0    vs active level (0 = active low)
// PORTS
//  clk                 in   1       pixel clock; all inputs are synchronous to it
//  rst                 in   1       asynchronous, active-high reset
//  i_lcd_de            in   1       data enable; pixel is valid when high
//  i_lcd_hs            in   1       line sync (informational only; line end = de falling edge)
//  i_lcd_vs            in   1       frame sync, polarity set by VS_POL
//  i_lcd_rgb           in   24      {R[7:0],G[7:0],B[7:0]}
//  i_sdram_init_done   in   1       SDRAM initialisation complete
//  o_wr_en             out  1       write FIFO push
//  o_wr_data           out  DATA_W  packed word; pixel 0 in bits [15:0]
//  o_wr_load           out  1       1-cycle pulse; resets the write address and clears the write FIFO
//  o_frame_done        out  1       1-cycle pulse after the last pad word of a frame
//  o_err_frame         out  1       sticky; set on a geometry mismatch; cleared only by rst
//  o_frame_cnt         out  16      count of good frames, wraps at 0xFFFF
// BEHAVIOUR
//  - Reset: all outputs 0; state = WAIT_INIT; packer and counters cleared.
//  - Frame start (fs): the cycle on which vs_d (vs registered once) moves from inactive to active.
//  - RGB565 = {R[7:3],G[7:2],B[7:3]}.
//  - States:
//    * WAIT_INIT: wait for i_sdram_init_done, then go to WAIT_VS.
//    * WAIT_VS: on fs, pulse o_wr_load (first frame after init only), clear counters, go to CAPTURE.
//    * CAPTURE: each de=1 cycle shifts one pixel into the packer.
//      - When the PPW-th pixel arrives, o_wr_en=1 and o_wr_data=word on the NEXT cycle (latency 1).
//      - Packing is continuous across lines.
//      - On de falling edge: if pix_cnt != H_DISP, set err; line_cnt++; pix_cnt=0.
//      - When line_cnt reaches V_DISP, go to PAD.
//    * PAD: push a zero word every cycle until word_cnt % BURST_LEN == 0.
//      - Then pulse o_frame_done; o_frame_cnt++ if the frame had no error; go to WAIT_VS.
//      - If no padding is needed, go straight to WAIT_VS and pulse o_frame_done in the same cycle.
//  - fs arriving in CAPTURE before V_DISP lines (short frame):
//    * set o_err_frame; discard any partial word; pulse o_wr_load; restart CAPTURE for the new frame.
//    * The same cycle's de pixel belongs to the new frame.
//  - de=1 outside CAPTURE: ignored. Extra pixels beyond H_DISP in a line: not written, err set.
//  - fs during PAD: set err; pad is abandoned; handled as a short frame.
//  - The next frame following any error frame also begins with an o_wr_load pulse.
//  - rst asserted mid-frame: immediate return to WAIT_INIT, no further writes; the next capture starts with o_wr_load.
//  - i_sdram_init_done dropping: return to WAIT_INIT at the next cycle.
//  - Counter widths: pix 12b, line 12b, word_cnt log2(BURST_LEN)b (mod counter).
// STRUCTURE
//  - Shared header (alongside sdram_timing.v): state encoding, RGB888->565 macro/function,
//    frame word-length macro ceil(H*V/PPW/BURST)*BURST.
//  - One sub-module, rgb_pixel_packer: PPW-deep shift/pack register with push, flush and word_valid.
//  - FSM and counters live in lcd_rgb_capture.
// TESTING (H_DISP=6, V_DISP=4, DATA_W=64, BURST_LEN=4, VS_POL=0)
//  1. Reset, init_done=1, one clean frame with pixel values 0..23 (as RGB565 after conversion):
//     -> o_wr_load once; 6 data words (word0 = {px3,px2,px1,px0}); then 2 zero words;
//     -> o_frame_done; o_frame_cnt=1; err=0.
//  2. rgb=24'hFF8040 on every pixel -> every data lane = 16'hFC08.
//  3. Line 2 carries only 5 pixels -> o_err_frame=1; o_frame_cnt does not increment;
//     the next frame starts with an o_wr_load pulse.
//  4. vs re-asserted after 2 lines -> no further words for the old frame;
//     o_wr_load pulse; the new frame is captured completely (8 words).
//  5. rst asserted during line 3 -> all outputs 0 within one cycle, state WAIT_INIT;
//     after release the next full frame is written correctly.
//  6. init_done=0 while video runs -> no wr_en; capture begins at the first fs after init_done rises.

Source files
------------

// File: rtl/lcd_rgb_capture_pkg.sv
// Shared types and helpers for the LCD RGB capture path: state encoding,
// RGB888 to RGB565 conversion and the padded frame length in FIFO words.
package lcd_rgb_capture_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_INIT = 2'd0,
        ST_WAIT_VS   = 2'd1,
        ST_CAPTURE   = 2'd2,
        ST_PAD       = 2'd3
    } cap_state_e;

    function automatic logic [15:0] rgb888_to_565(input logic [23:0] rgb);
        return {rgb[23:19], rgb[15:10], rgb[7:3]};
    endfunction

    // Words occupied by one frame once rounded up to whole bursts.
    function automatic int frame_words(input int h, input int v, input int ppw, input int burst);
        return ((h * v / ppw + burst - 1) / burst) * burst;
    endfunction

endpackage

// File: rtl/lcd_rgb_capture_packer.sv
// Packs 16-bit pixels into DATA_W-bit words, first pixel in the low lane.
// o_word/o_word_valid are combinational so the caller can register them.
module rgb_pixel_packer #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              flush,
    input  logic [15:0]       i_pix,
    output logic [DATA_W-1:0] o_word,
    output logic              o_word_valid
);
    localparam int PPW = DATA_W / 16;
    localparam int CW  = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int SW  = (PPW - 1) * 16;

    logic [SW-1:0]     data_q, data_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] ext;
    logic              last;

    assign ext          = {i_pix, data_q};
    assign last         = (cnt_q == CW'(PPW - 1));
    assign o_word       = ext;
    assign o_word_valid = push && !flush && last;

    // A flush drops any partial word; a pixel pushed alongside it starts the new word.
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (push) begin
            data_d = ext[DATA_W-1:16];
        end
        if (flush) begin
            cnt_d = push ? CW'(1) : '0;
        end else if (push) begin
            cnt_d = last ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/lcd_rgb_capture.sv
// Captures an RGB888 LCD stream, converts to RGB565, packs into FIFO words
// and pads every frame with zero words to a whole number of bursts.
module lcd_rgb_capture
    import lcd_rgb_capture_pkg::*;
#(
    parameter int H_DISP    = 800,
    parameter int V_DISP    = 480,
    parameter int DATA_W    = 64,
    parameter int BURST_LEN = 256,
    parameter int VS_POL    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_lcd_de,
    input  logic              i_lcd_hs,
    input  logic              i_lcd_vs,
    input  logic [23:0]       i_lcd_rgb,
    input  logic              i_sdram_init_done,
    output logic              o_wr_en,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_wr_load,
    output logic              o_frame_done,
    output logic              o_err_frame,
    output logic [15:0]       o_frame_cnt
);
    localparam int         WCW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic       VS_ACT = (VS_POL != 0);
    localparam logic [11:0] H_LEN = 12'(H_DISP);
    localparam logic [11:0] V_LEN = 12'(V_DISP);

    cap_state_e        state_q, state_d;
    logic              vs1_q, vs1_d, vs2_q, vs2_d, de_prev_q, de_prev_d;
    logic [11:0]       pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d;
    logic [WCW-1:0]    word_cnt_q, word_cnt_d;
    logic              frame_err_q, frame_err_d, load_pending_q, load_pending_d;
    logic              wr_en_q, wr_en_d, wr_load_q, wr_load_d, frame_done_q, frame_done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;

    logic              fs, de_fall, start_frame, push, finish, word_valid;
    logic [DATA_W-1:0] word;
    logic              unused_hs;

    assign unused_hs   = i_lcd_hs;
    // vs1 is the once-registered vs; a frame starts when it first turns active.
    assign fs          = (vs1_q == VS_ACT) && (vs2_q != VS_ACT);
    assign de_fall     = de_prev_q && !i_lcd_de;
    assign start_frame = i_sdram_init_done && fs && (state_q != ST_WAIT_INIT);
    assign push        = i_sdram_init_done && i_lcd_de &&
                         (start_frame || (state_q == ST_CAPTURE && pix_cnt_q < H_LEN));

    rgb_pixel_packer #(.DATA_W(DATA_W)) u_packer (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .flush        (start_frame),
        .i_pix        (rgb888_to_565(i_lcd_rgb)),
        .o_word       (word),
        .o_word_valid (word_valid)
    );

    always_comb begin
        vs1_d          = i_lcd_vs;
        vs2_d          = vs1_q;
        de_prev_d      = i_lcd_de;
        state_d        = state_q;
        pix_cnt_d      = pix_cnt_q;
        line_cnt_d     = line_cnt_q;
        word_cnt_d     = word_cnt_q;
        frame_err_d    = frame_err_q;
        load_pending_d = load_pending_q;
        err_d          = err_q;
        frame_cnt_d    = frame_cnt_q;
        wr_en_d        = 1'b0;
        wr_data_d      = '0;
        wr_load_d      = 1'b0;
        frame_done_d   = 1'b0;
        finish         = 1'b0;
        if (!i_sdram_init_done) begin
            state_d        = ST_WAIT_INIT;
            load_pending_d = 1'b1;
        end else begin
            case (state_q)
                ST_WAIT_INIT: state_d = ST_WAIT_VS;
                ST_WAIT_VS: begin
                    if (fs) wr_load_d = load_pending_q;
                end
                ST_CAPTURE: begin
                    if (fs) begin
                        err_d     = 1'b1;
                        wr_load_d = 1'b1;
                    end else begin
                        if (i_lcd_de) begin
                            pix_cnt_d = pix_cnt_q + 12'd1;
                            if (!push) begin
                                err_d       = 1'b1;
                                frame_err_d = 1'b1;
                            end
                        end
                        if (word_valid) begin
                            wr_en_d    = 1'b1;
                            wr_data_d  = word;
                            word_cnt_d = word_cnt_q + WCW'(1);
                        end
                        if (de_fall) begin
                            if (pix_cnt_q != H_LEN) begin
                                err_d       = 1'b1;
                                frame_err_d = 1'b1;
                            end
                            line_cnt_d = line_cnt_q + 12'd1;
                            pix_cnt_d  = '0;
                            if (line_cnt_q + 12'd1 == V_LEN) begin
                                if (word_cnt_q == '0) finish  = 1'b1;
                                else                  state_d = ST_PAD;
                            end
                        end
                    end
                end
                ST_PAD: begin
                    if (fs) begin
                        err_d     = 1'b1;
                        wr_load_d = 1'b1;
                    end else if (word_cnt_q == '0) begin
                        finish = 1'b1;
                    end else begin
                        wr_en_d    = 1'b1;
                        word_cnt_d = word_cnt_q + WCW'(1);
                    end
                end
                default: state_d = ST_WAIT_INIT;
            endcase
            if (start_frame) begin
                state_d        = ST_CAPTURE;
                pix_cnt_d      = i_lcd_de ? 12'd1 : 12'd0;
                line_cnt_d     = '0;
                word_cnt_d     = '0;
                frame_err_d    = 1'b0;
                load_pending_d = 1'b0;
            end
            // A bad frame still completes, but forces a FIFO reload before the next one.
            if (finish) begin
                state_d      = ST_WAIT_VS;
                frame_done_d = 1'b1;
                if (frame_err_d) load_pending_d = 1'b1;
                else             frame_cnt_d    = frame_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_WAIT_INIT;
            vs1_q          <= VS_ACT;
            vs2_q          <= VS_ACT;
            de_prev_q      <= 1'b0;
            pix_cnt_q      <= '0;
            line_cnt_q     <= '0;
            word_cnt_q     <= '0;
            frame_err_q    <= 1'b0;
            load_pending_q <= 1'b1;
            err_q          <= 1'b0;
            frame_cnt_q    <= '0;
            wr_en_q        <= 1'b0;
            wr_data_q      <= '0;
            wr_load_q      <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            vs1_q          <= vs1_d;
            vs2_q          <= vs2_d;
            de_prev_q      <= de_prev_d;
            pix_cnt_q      <= pix_cnt_d;
            line_cnt_q     <= line_cnt_d;
            word_cnt_q     <= word_cnt_d;
            frame_err_q    <= frame_err_d;
            load_pending_q <= load_pending_d;
            err_q          <= err_d;
            frame_cnt_q    <= frame_cnt_d;
            wr_en_q        <= wr_en_d;
            wr_data_q      <= wr_data_d;
            wr_load_q      <= wr_load_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign o_wr_en      = wr_en_q;
    assign o_wr_data    = wr_data_q;
    assign o_wr_load    = wr_load_q;
    assign o_frame_done = frame_done_q;
    assign o_err_frame  = err_q;
    assign o_frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_lcd_rgb_capture.sv
// Scoreboard bench for lcd_rgb_capture: a frame-level model queues the expected
// load / word / done events while stimulus is driven; a monitor pops and compares.
module tb_lcd_rgb_capture;
    localparam int H   = 6;
    localparam int V   = 4;
    localparam int DW  = 64;
    localparam int BL  = 4;
    localparam int PPW = DW / 16;
    localparam int K_LOAD = 0;
    localparam int K_WORD = 1;
    localparam int K_DONE = 2;

    logic          clk = 1'b0;
    logic          rst, de, hs, vs, init;
    logic [23:0]   rgb;
    logic          wr_en, wr_load, frame_done, err_frame;
    logic [DW-1:0] wr_data;
    logic [15:0]   frame_cnt;

    always #5 clk = ~clk;

    lcd_rgb_capture #(
        .H_DISP(H), .V_DISP(V), .DATA_W(DW), .BURST_LEN(BL), .VS_POL(0)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_lcd_de          (de),
        .i_lcd_hs          (hs),
        .i_lcd_vs          (vs),
        .i_lcd_rgb         (rgb),
        .i_sdram_init_done (init),
        .o_wr_en           (wr_en),
        .o_wr_data         (wr_data),
        .o_wr_load         (wr_load),
        .o_frame_done      (frame_done),
        .o_err_frame       (err_frame),
        .o_frame_cnt       (frame_cnt)
    );

    typedef struct {
        int          kind;
        logic [63:0] data;
        int          cnt;
        int          err;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model state, one frame at a time.
    bit          m_cap = 0;
    bit          m_ferr = 0;
    bit          m_err = 0;
    bit          m_loadp = 1;
    int          m_lines = 0;
    int          m_pix = 0;
    int          m_words = 0;
    int          m_cnt = 0;
    logic [15:0] m_buf[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] to565(input logic [23:0] c);
        int r, g, b;
        r = (c >> 16) & 255;
        g = (c >> 8) & 255;
        b = c & 255;
        return 16'(((r / 8) << 11) | ((g / 4) << 5) | (b / 8));
    endfunction

    task automatic push_exp(input int kind, input logic [63:0] d);
        exp_t e;
        e.kind = kind;
        e.data = d;
        e.cnt  = m_cnt;
        e.err  = m_err;
        exp_q.push_back(e);
    endtask

    task automatic model_start();
        if (!init) begin
            m_cap = 0;
        end else begin
            if (m_cap) begin
                m_err = 1;
                push_exp(K_LOAD, 0);
            end else if (m_loadp) begin
                push_exp(K_LOAD, 0);
                m_loadp = 0;
            end
            m_cap = 1;
            m_lines = 0;
            m_pix = 0;
            m_words = 0;
            m_ferr = 0;
            m_buf.delete();
        end
    endtask

    task automatic model_pixel(input logic [23:0] c);
        logic [63:0] w;
        if (m_cap) begin
            if (m_pix < H) begin
                m_buf.push_back(to565(c));
                if (m_buf.size() == PPW) begin
                    w = '0;
                    for (int i = 0; i < PPW; i++) w = w | (64'(m_buf[i]) << (16 * i));
                    push_exp(K_WORD, w);
                    m_words++;
                    m_buf.delete();
                end
            end else begin
                m_ferr = 1;
                m_err = 1;
            end
            m_pix++;
        end
    endtask

    task automatic model_line_end();
        if (m_cap) begin
            if (m_pix != H) begin
                m_ferr = 1;
                m_err = 1;
            end
            m_lines++;
            m_pix = 0;
            if (m_lines == V) begin
                while (m_words % BL != 0) begin
                    push_exp(K_WORD, 0);
                    m_words++;
                end
                if (m_ferr) m_loadp = 1;
                else        m_cnt++;
                push_exp(K_DONE, 0);
                m_cap = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        de = 0;
        hs = 0;
        repeat (n) @(negedge clk);
        hs = 1;
    endtask

    task automatic drive_pixel(input logic [23:0] c);
        de = 1;
        rgb = c;
        model_pixel(c);
        @(negedge clk);
    endtask

    task automatic start_vs();
        model_start();
        vs = 0;
        repeat (2) @(negedge clk);
        vs = 1;
        idle(3);
    endtask

    // mode 0: RGB565 value equals pixel index; 1: constant FF8040; 2: random
    task automatic drive_frame(input int nlines, input int odd_line, input int odd_len,
                               input int mode, input int init_line);
        int idx = 0;
        int n;
        logic [23:0] c;
        start_vs();
        for (int l = 0; l < nlines; l++) begin
            if (l == init_line) init = 1;
            n = (l == odd_line) ? odd_len : H;
            for (int p = 0; p < n; p++) begin
                if (mode == 0)      c = 24'((((idx >> 11) & 31) << 19) | (((idx >> 5) & 63) << 10) | ((idx & 31) << 3));
                else if (mode == 1) c = 24'hFF8040;
                else                c = 24'($urandom);
                drive_pixel(c);
                idx++;
            end
            model_line_end();
            idle(3);
        end
        if (nlines == V) idle(8);
    endtask

    task automatic pop_check(input int kind, input logic [63:0] d, input logic [15:0] cnt, input logic err);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event kind=%0d actual=%h required=none at %0t", kind, d, $time);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", 64'(kind), 64'(e.kind));
            if (e.kind == kind && kind == K_WORD) chk("wr_data", d, e.data);
            if (e.kind == kind && kind == K_DONE) begin
                chk("frame_cnt", 64'(cnt), 64'(e.cnt));
                chk("err_frame", 64'(err), 64'(e.err));
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_load)    pop_check(K_LOAD, 0, 0, 0);
            if (wr_en)      pop_check(K_WORD, wr_data, 0, 0);
            if (frame_done) pop_check(K_DONE, 0, frame_cnt, err_frame);
        end
    end

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_wr_en"}, 64'(wr_en), 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_wr_load"}, 64'(wr_load), 0);
        chk({tag, "_frame_done"}, 64'(frame_done), 0);
        chk({tag, "_err_frame"}, 64'(err_frame), 0);
        chk({tag, "_frame_cnt"}, 64'(frame_cnt), 0);
    endtask

    initial begin
        rst = 1; init = 0; de = 0; hs = 1; vs = 1; rgb = '0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 0;
        init = 1;
        idle(5);

        drive_frame(V, -1, 0, 0, -1);              // clean frame, pixels 0..23
        drive_frame(V, -1, 0, 1, -1);              // constant FF8040 -> FC08
        drive_frame(V, 1, 5, 2, -1);               // short line 2
        drive_frame(V, -1, 0, 2, -1);              // reload after error frame
        drive_frame(2, -1, 0, 2, -1);              // aborted after 2 lines
        drive_frame(V, -1, 0, 2, -1);              // new frame captured in full

        drive_frame(2, -1, 0, 2, -1);              // reset during line 3
        for (int p = 0; p < 3; p++) drive_pixel(24'($urandom));
        #2;
        rst = 1;
        de = 0;
        #1;
        chk_outputs_zero("midframe_rst");
        chk("queue_empty_at_rst", 64'(exp_q.size()), 0);
        exp_q.delete();
        m_cap = 0; m_loadp = 1; m_err = 0; m_cnt = 0; m_buf.delete();
        repeat (2) @(negedge clk);
        rst = 0;
        idle(5);
        drive_frame(V, -1, 0, 2, -1);

        init = 0;                                  // SDRAM not ready
        m_loadp = 1;
        m_cap = 0;
        idle(4);
        drive_frame(V, -1, 0, 2, -1);
        drive_frame(V, -1, 0, 2, 1);               // init rises mid-frame
        drive_frame(V, -1, 0, 2, -1);

        for (int k = 0; k < 4; k++) drive_frame(V, (k == 1) ? 2 : -1, 7, 2, -1);

        idle(20);
        chk("queue_empty_at_end", 64'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
